// File: rtl/ac_ir_pkg.sv
// ---------------------------------------------------------------------------
// ac_ir_pkg
// Shared types and constants for the air-conditioner IR settings encoder:
// mode encodings, temperature limits, the fixed frame fields, the event and
// FSM enumerations, the settings record and the frame checksum.
// ---------------------------------------------------------------------------
package ac_ir_pkg;

  typedef enum logic [2:0] {
    MODE_AUTO = 3'd0,
    MODE_COOL = 3'd1,
    MODE_DRY  = 3'd2,
    MODE_FAN  = 3'd3,
    MODE_HEAT = 3'd4
  } mode_e;

  localparam logic [4:0]  TEMP_MIN   = 5'd16;
  localparam logic [4:0]  TEMP_MAX   = 5'd30;
  localparam logic [4:0]  TEMP_RESET = 5'd26;

  // Constant tails of the two frame words.
  localparam logic [24:0] FIXED35_LO = 25'h0080052;
  localparam logic [27:0] FIXED32_LO = 28'h8040006;

  // Button positions inside the press vector; lower index wins on a tie.
  localparam int unsigned BTN_POWER     = 0;
  localparam int unsigned BTN_MODE      = 1;
  localparam int unsigned BTN_TEMP_UP   = 2;
  localparam int unsigned BTN_TEMP_DOWN = 3;
  localparam int unsigned BTN_FAN       = 4;
  localparam int unsigned NUM_BTNS      = 5;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_POWER,
    EV_MODE,
    EV_TEMP_UP,
    EV_TEMP_DOWN,
    EV_FAN
  } event_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLDOFF,
    ST_PUBLISH
  } state_e;

  typedef struct packed {
    logic       power_on;
    mode_e      mode;
    logic [4:0] temp_c;
    logic [1:0] fan;
  } settings_t;

  localparam settings_t SETTINGS_RESET = '{
    power_on: 1'b0,
    mode:     MODE_COOL,
    temp_c:   TEMP_RESET,
    fan:      2'd0
  };

  function automatic mode_e next_mode(input mode_e m);
    return (m == MODE_HEAT) ? MODE_AUTO : mode_e'(m + 3'd1);
  endfunction

  // 4-bit wrapping sum over the variable fields plus a constant 0xA.
  function automatic logic [3:0] checksum(input settings_t s);
    logic [3:0] sum;
    sum = 4'(s.mode) + 4'(s.temp_c - TEMP_MIN) + {3'b000, s.power_on}
        + {2'b00, s.fan} + 4'hA;
    return sum;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// One pushbutton: 2-FF synchronizer, stability counter and a single-cycle
// press pulse on each accepted 0->1 transition. A button already held when
// reset is released is ignored until it has been seen released.
//
// Ports
//   clk      system clock
//   rst      synchronous, active-low reset
//   btn_i    raw asynchronous active-high button
//   press_o  one-cycle pulse on an accepted press
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             block_q, block_d;
  logic             press_q, press_d;
  logic             differs;
  logic             accept;

  // NOTE: the synchronizer flops deliberately have no reset: they keep
  // sampling the pin while rst is low, so a button held across reset is
  // already visible when reset is released and can be blocked.
  always_ff @(posedge clk) begin
    sync1_q <= btn_i;
    sync2_q <= sync1_q;
  end

  // NOTE: every signal driven here gets a default at the top of the block so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    differs = (sync2_q != level_q);
    accept  = differs && (cnt_q == CNT_LAST);
    level_d = level_q;
    cnt_d   = '0;                         // any sample equal to level restarts
    if (differs) begin
      if (accept) level_d = sync2_q;
      else        cnt_d   = cnt_q + 1'b1;
    end
    press_d = accept && sync2_q && !block_q;
    // The block clears once the button is released and the accepted level is low.
    block_d = block_q && !(!sync2_q && !level_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the clock edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      block_q <= sync2_q;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      block_q <= block_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/ac_settings_encoder.sv
// ---------------------------------------------------------------------------
// ac_settings_encoder
// Debounces five AC remote buttons, maintains the current settings and, after
// a quiet hold-off following the last applied change, publishes a two-word IR
// frame (35-bit + 32-bit) with a one-cycle frame_valid pulse.
//
// Ports
//   clk, rst                         clock, synchronous active-low reset
//   btn_power .. btn_fan             raw active-high pushbuttons
//   ir_data35_1 / ir_data35_0        frame word35 bits 34..3 / 2..0
//   ir_data32                        frame word32
//   frame_valid                      pulse on the cycle the frame changes
//   power_on, mode, temp_c, fan      current settings for display
// ---------------------------------------------------------------------------
module ac_settings_encoder
  import ac_ir_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned HOLDOFF_CYCLES  = 10_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_power,
  input  logic        btn_mode,
  input  logic        btn_temp_up,
  input  logic        btn_temp_down,
  input  logic        btn_fan,
  output logic [31:0] ir_data35_1,
  output logic [2:0]  ir_data35_0,
  output logic [31:0] ir_data32,
  output logic        frame_valid,
  output logic        power_on,
  output logic [2:0]  mode,
  output logic [4:0]  temp_c,
  output logic [1:0]  fan
);

  localparam int unsigned HOLD_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF_CYCLES - 1);

  logic [NUM_BTNS-1:0] btn_raw;
  logic [NUM_BTNS-1:0] press;
  event_e              ev;
  settings_t           settings_q, settings_d;
  logic                change;
  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic                publish;
  logic [34:0]         word35;
  logic [31:0]         word32;
  logic [34:0]         frame35_q;
  logic [31:0]         frame32_q;
  logic                frame_valid_q;

  assign btn_raw[BTN_POWER]     = btn_power;
  assign btn_raw[BTN_MODE]      = btn_mode;
  assign btn_raw[BTN_TEMP_UP]   = btn_temp_up;
  assign btn_raw[BTN_TEMP_DOWN] = btn_temp_down;
  assign btn_raw[BTN_FAN]       = btn_fan;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[i]),
      .press_o(press[i])
    );
  end

  // Only the highest-priority press of a cycle is applied.
  always_comb begin
    ev = EV_NONE;
    if      (press[BTN_POWER])     ev = EV_POWER;
    else if (press[BTN_MODE])      ev = EV_MODE;
    else if (press[BTN_TEMP_UP])   ev = EV_TEMP_UP;
    else if (press[BTN_TEMP_DOWN]) ev = EV_TEMP_DOWN;
    else if (press[BTN_FAN])       ev = EV_FAN;
  end

  // change is raised only when the event actually alters a setting.
  always_comb begin
    settings_d = settings_q;
    change     = 1'b0;
    case (ev)
      EV_POWER: begin
        settings_d.power_on = !settings_q.power_on;
        change              = 1'b1;
      end
      EV_MODE: if (settings_q.power_on) begin
        settings_d.mode = next_mode(settings_q.mode);
        change          = 1'b1;
      end
      EV_TEMP_UP: if (settings_q.power_on && settings_q.temp_c != TEMP_MAX) begin
        settings_d.temp_c = settings_q.temp_c + 5'd1;
        change            = 1'b1;
      end
      EV_TEMP_DOWN: if (settings_q.power_on && settings_q.temp_c != TEMP_MIN) begin
        settings_d.temp_c = settings_q.temp_c - 5'd1;
        change            = 1'b1;
      end
      EV_FAN: if (settings_q.power_on) begin
        settings_d.fan = settings_q.fan + 2'd1;   // 3 wraps to 0
        change         = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) settings_q <= SETTINGS_RESET;
    else      settings_q <= settings_d;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (change) state_d = ST_HOLDOFF;
      ST_HOLDOFF: if (!change && hold_cnt_q == '0) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = change ? ST_HOLDOFF : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs. Any applied change restarts the hold-off, whatever the state.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    publish    = (state_q == ST_PUBLISH);
    if (change)
      hold_cnt_d = HOLD_LAST;
    else if (state_q == ST_HOLDOFF && hold_cnt_q != '0)
      hold_cnt_d = hold_cnt_q - 1'b1;
  end

  assign word35 = {settings_q.mode, settings_q.power_on, settings_q.fan,
                   4'(settings_q.temp_c - TEMP_MIN), FIXED35_LO};
  assign word32 = {checksum(settings_q), FIXED32_LO};

  // Frame registers capture at the end of PUBLISH, so frame_valid and the
  // new words appear together on the following cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      frame35_q     <= '0;
      frame32_q     <= '0;
      frame_valid_q <= 1'b0;
    end else begin
      frame_valid_q <= publish;
      if (publish) begin
        frame35_q <= word35;
        frame32_q <= word32;
      end
    end
  end

  assign ir_data35_1 = frame35_q[34:3];
  assign ir_data35_0 = frame35_q[2:0];
  assign ir_data32   = frame32_q;
  assign frame_valid = frame_valid_q;
  assign power_on    = settings_q.power_on;
  assign mode        = settings_q.mode;
  assign temp_c      = settings_q.temp_c;
  assign fan         = settings_q.fan;

endmodule

// File: doc/ac_settings_encoder.md
AC_SETTINGS_ENCODER -- requirements
Module: ac_settings_encoder

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 2_000_000, is the number of consecutive stable cycles required to accept a button level (20 ms at 100 MHz).
REQ-002 Parameter HOLDOFF_CYCLES, default 10_000_000, is the quiet time after the last applied change before a frame is published (100 ms).
REQ-003 Port clk, input, 1, is the 100 MHz system clock.
REQ-004 Port rst, input, 1, is the reset: synchronous, active-low, on clock clk.
REQ-005 Ports btn_power, btn_mode, btn_temp_up, btn_temp_down and btn_fan are inputs, 1 bit each, raw asynchronous active-high pushbuttons.
REQ-006 Port ir_data35_1, output, 32 bits, carries bits 34..3 of the 35-bit frame word.
REQ-007 Port ir_data35_0, output, 3 bits, carries bits 2..0 of the 35-bit frame word.
REQ-008 Port ir_data32, output, 32 bits, carries the second frame word.
REQ-009 Port frame_valid, output, 1 bit, is a one-cycle pulse on the cycle the frame outputs change.
REQ-010 Ports power_on (1), mode (3), temp_c (5) and fan (2) are outputs showing the current settings for display and LED.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer and then a stability counter; a new level SHALL be accepted only after DEBOUNCE_CYCLES consecutive equal synchronized samples, and any differing sample SHALL restart the count.
REQ-012 A press event SHALL be a single-cycle pulse on an accepted 0->1 transition; release SHALL generate no event, so a held button yields exactly one event.
REQ-013 If several events occur in the same cycle, priority SHALL be power > mode > temp_up > temp_down > fan; only the highest SHALL be applied and the rest SHALL be dropped.
REQ-014 power SHALL toggle power_on; while power_on=0, every other event SHALL be ignored and SHALL NOT count as a change.
REQ-015 mode SHALL step 0 auto > 1 cool > 2 dry > 3 fan > 4 heat and wrap from 4 to 0.
REQ-016 temp_up and temp_down SHALL step temp_c within 16..30 and saturate at the limits; a saturated press SHALL NOT count as a change.
REQ-017 fan SHALL step 0..3 and wrap from 3 to 0.
REQ-018 Settings SHALL update on the cycle after the event.
REQ-019 The control FSM states SHALL be IDLE, HOLDOFF and PUBLISH.
REQ-020 FSM transitions SHALL be:
- IDLE > HOLDOFF on an applied change, loading the counter with HOLDOFF_CYCLES-1.
- In HOLDOFF, a further applied change SHALL reload the counter; otherwise the counter decrements, and at 0 the FSM goes to PUBLISH.
- PUBLISH SHALL last one cycle and return to IDLE.
REQ-021 In PUBLISH, the frame registers SHALL load from the current settings and frame_valid SHALL be 1; at all other times frame_valid=0 and the frame outputs SHALL hold.
REQ-022 The frame SHALL publish exactly HOLDOFF_CYCLES+1 cycles after the settings update of the last change.
REQ-023 An applied change arriving in the PUBLISH cycle SHALL enter HOLDOFF on the next cycle, which means a second frame follows.
REQ-024 Frame layout (transmitted MSB first):
- word35[34:32] = mode; [31] = power_on; [30:29] = fan; [28:25] = temp_c-16; [24:0] = FIXED35_LO = 25'h0080052.
- word32[31:28] = checksum; [27:0] = FIXED32_LO = 28'h8040006.
REQ-025 checksum SHALL be (mode + (temp_c-16) + power_on + fan + 4'hA) mod 16, computed in a 4-bit wrapping sum.

Reset
REQ-026 While rst=0, settings SHALL reset to power_on=0, mode=1, temp_c=26, fan=0.
REQ-027 While rst=0, all frame outputs SHALL be 0, frame_valid=0, the FSM SHALL be in IDLE, and the debounce state SHALL read as released.
REQ-028 Reset asserted during HOLDOFF or PUBLISH SHALL discard the pending frame; no frame_valid SHALL appear.
REQ-029 A button held through reset release SHALL NOT produce an event until it is released and pressed again.

Structure
REQ-030 Package ac_ir_pkg SHALL hold the mode encodings, TEMP_MIN=16, TEMP_MAX=30, FIXED35_LO, FIXED32_LO and the checksum function.
REQ-031 Sub-module btn_debounce (synchronizer, stability counter, rising-event pulse) SHALL be instantiated five times.

Verification (DEBOUNCE_CYCLES=16, HOLDOFF_CYCLES=64)
REQ-032 Power-on: press btn_power for 40 cycles from reset -> power_on=1; exactly one frame_valid; word35 = {3'd1,1'b1,2'd0,4'd10,FIXED35_LO}; ir_data32[31:28] = 4'h6.
REQ-033 Bounce: btn_temp_up toggles every 5 cycles, then holds 1 -> exactly one increment (26 to 27); no event occurs during the toggling.
REQ-034 Saturation/off: with power_on=0, press mode -> no frame. With power on, 20 temp_up presses -> temp_c=30, checksum 4'hA, and one frame after the final applied change.
REQ-035 Coalescing: mode, fan and temp_down presses spaced 30 cycles apart -> a single frame carrying mode=2, fan=1, temp_c=25, published 65 cycles after the last update.
REQ-036 Simultaneous/reset: power and fan accepted in the same cycle -> only power toggles. Reset asserted 10 cycles into HOLDOFF -> no frame_valid, and outputs return to their reset values.
